// File: rtl/usb_tx_pkg.sv
// Shared types and constants for the USB transmit packet sequencer.
// CRC polynomials are in MSB-first (non-reflected) form to match the serial shifter.
package usb_tx_pkg;

  typedef enum logic [1:0] {
    PKT_TOKEN     = 2'b00,
    PKT_DATA      = 2'b01,
    PKT_HANDSHAKE = 2'b10,
    PKT_RSVD      = 2'b11
  } pkt_type_t;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_SYNC,
    ST_PID,
    ST_TOKEN_BITS,
    ST_DATA_BITS,
    ST_CRC5,
    ST_CRC16,
    ST_EOP_SE0,
    ST_EOP_J
  } state_t;

  localparam logic [7:0]  SYNC_PATTERN = 8'h80;
  localparam logic [4:0]  CRC5_POLY    = 5'h05;
  localparam logic [4:0]  CRC5_INIT    = 5'h1F;
  localparam logic [15:0] CRC16_POLY   = 16'h8005;
  localparam logic [15:0] CRC16_INIT   = 16'hFFFF;

  localparam logic [3:0] PID_OUT   = 4'h1;
  localparam logic [3:0] PID_IN    = 4'h9;
  localparam logic [3:0] PID_DATA0 = 4'h3;
  localparam logic [3:0] PID_DATA1 = 4'hB;
  localparam logic [3:0] PID_ACK   = 4'h2;
  localparam logic [3:0] PID_NAK   = 4'hA;

  // Index of the final bit time of each field.
  function automatic logic [3:0] field_last(input state_t s);
    case (s)
      ST_SYNC, ST_PID, ST_DATA_BITS: field_last = 4'd7;
      ST_TOKEN_BITS:                 field_last = 4'd10;
      ST_CRC5:                       field_last = 4'd4;
      ST_CRC16:                      field_last = 4'd15;
      ST_EOP_SE0:                    field_last = 4'd1;
      default:                       field_last = 4'd0;
    endcase
  endfunction

endpackage

// File: rtl/usb_serial_crc.sv
// Bit-serial CRC register, MSB-first shift; init has priority over en.
module usb_serial_crc #(
  parameter int unsigned       WIDTH = 5,
  parameter logic [WIDTH-1:0]  POLY  = '0,
  parameter logic [WIDTH-1:0]  INIT  = '1
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             init,
  input  logic             en,
  input  logic             din,
  output logic [WIDTH-1:0] crc
);

  logic [WIDTH-1:0] crc_q, crc_d;
  logic             fb;

  always_comb begin
    crc_d = crc_q;
    fb    = crc_q[WIDTH-1] ^ din;
    if (init) begin
      crc_d = INIT;
    end else if (en) begin
      crc_d = {crc_q[WIDTH-2:0], 1'b0} ^ (fb ? POLY : '0);
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) crc_q <= '0;
    else        crc_q <= crc_d;
  end

  assign crc = crc_q;

endmodule

// File: rtl/usb_tx_pkt_seq.sv
// USB transmit packet sequencer: SYNC, PID, token/payload, CRC and EOP,
// one bit per bit_en strobe, feeding the bit-stuff/NRZI stage.
module usb_tx_pkt_seq
  import usb_tx_pkg::*;
#(
  parameter int unsigned MAX_DATA_BYTES = 64,
  parameter int unsigned LEN_W          = $clog2(MAX_DATA_BYTES + 1)
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             start,
  input  logic [1:0]       pkt_type,
  input  logic [3:0]       pid,
  input  logic [10:0]      token_field,
  input  logic [LEN_W-1:0] data_len,
  input  logic [7:0]       data_byte,
  input  logic             bit_en,
  output logic             data_rd,
  output logic             tx_bit,
  output logic             tx_se0,
  output logic             tx_active,
  output logic             ready,
  output logic             done
);

  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_DATA_BYTES);

  state_t           state_q, state_d;
  logic [3:0]       bit_cnt_q, bit_cnt_d;
  logic [LEN_W-1:0] byte_cnt_q, byte_cnt_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [7:0]       shift_q, shift_d;
  logic             load_q, load_d;
  logic             done_q, done_d;
  pkt_type_t        type_q, type_d;
  logic [3:0]       pid_q, pid_d;
  logic [10:0]      token_q, token_d;

  logic [4:0]       crc5;
  logic [15:0]      crc16;
  logic [7:0]       pid_byte;
  logic [2:0]       crc5_idx;
  logic [LEN_W-1:0] len_clamped;
  logic             accept;
  logic             cur_bit;
  logic             bit_last;

  assign accept      = start && (state_q == ST_IDLE);
  assign len_clamped = (data_len > MAX_LEN) ? MAX_LEN : data_len;
  assign pid_byte    = {~pid_q, pid_q};
  assign crc5_idx    = 3'd4 - bit_cnt_q[2:0];
  assign bit_last    = (bit_cnt_q == field_last(state_q));

  // While a byte is being popped the shift register is not loaded yet,
  // so the line bit comes straight from the FIFO head.
  always_comb begin
    cur_bit = 1'b1;
    case (state_q)
      ST_SYNC:       cur_bit = SYNC_PATTERN[bit_cnt_q[2:0]];
      ST_PID:        cur_bit = pid_byte[bit_cnt_q[2:0]];
      ST_TOKEN_BITS: cur_bit = token_q[bit_cnt_q];
      ST_DATA_BITS:  cur_bit = load_q ? data_byte[bit_cnt_q[2:0]] : shift_q[bit_cnt_q[2:0]];
      ST_CRC5:       cur_bit = ~crc5[crc5_idx];
      ST_CRC16:      cur_bit = ~crc16[~bit_cnt_q];
      ST_EOP_SE0:    cur_bit = 1'b0;
      default:       cur_bit = 1'b1;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    byte_cnt_d = byte_cnt_q;
    len_d      = len_q;
    shift_d    = shift_q;
    load_d     = load_q;
    done_d     = 1'b0;
    type_d     = type_q;
    pid_d      = pid_q;
    token_d    = token_q;

    if (accept) begin
      state_d    = ST_SYNC;
      bit_cnt_d  = '0;
      byte_cnt_d = '0;
      load_d     = 1'b0;
      type_d     = pkt_type_t'(pkt_type);
      pid_d      = pid;
      token_d    = token_field;
      len_d      = len_clamped;
    end else if (state_q != ST_IDLE) begin
      if (state_q == ST_DATA_BITS && load_q) begin
        shift_d = data_byte;
        load_d  = 1'b0;
      end
      if (bit_en) begin
        if (!bit_last) begin
          bit_cnt_d = bit_cnt_q + 4'd1;
        end else begin
          bit_cnt_d = '0;
          case (state_q)
            ST_SYNC: state_d = ST_PID;
            ST_PID: begin
              case (type_q)
                PKT_TOKEN: state_d = ST_TOKEN_BITS;
                PKT_DATA: begin
                  if (len_q == '0) begin
                    state_d = ST_CRC16;
                  end else begin
                    state_d = ST_DATA_BITS;
                    load_d  = 1'b1;
                  end
                end
                default: state_d = ST_EOP_SE0;
              endcase
            end
            ST_TOKEN_BITS: state_d = ST_CRC5;
            ST_DATA_BITS: begin
              byte_cnt_d = byte_cnt_q + 1'b1;
              if (byte_cnt_d == len_q) state_d = ST_CRC16;
              else                     load_d  = 1'b1;
            end
            ST_CRC5, ST_CRC16: state_d = ST_EOP_SE0;
            ST_EOP_SE0:        state_d = ST_EOP_J;
            ST_EOP_J: begin
              state_d = ST_IDLE;
              done_d  = 1'b1;
            end
            default: state_d = ST_IDLE;
          endcase
        end
      end
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q    <= ST_IDLE;
      bit_cnt_q  <= '0;
      byte_cnt_q <= '0;
      len_q      <= '0;
      shift_q    <= '0;
      load_q     <= 1'b0;
      done_q     <= 1'b0;
      type_q     <= PKT_TOKEN;
      pid_q      <= '0;
      token_q    <= '0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      len_q      <= len_d;
      shift_q    <= shift_d;
      load_q     <= load_d;
      done_q     <= done_d;
      type_q     <= type_d;
      pid_q      <= pid_d;
      token_q    <= token_d;
    end
  end

  usb_serial_crc #(
    .WIDTH (5),
    .POLY  (CRC5_POLY),
    .INIT  (CRC5_INIT)
  ) u_crc5 (
    .clk   (clk),
    .n_rst (n_rst),
    .init  (accept),
    .en    (bit_en && (state_q == ST_TOKEN_BITS)),
    .din   (cur_bit),
    .crc   (crc5)
  );

  usb_serial_crc #(
    .WIDTH (16),
    .POLY  (CRC16_POLY),
    .INIT  (CRC16_INIT)
  ) u_crc16 (
    .clk   (clk),
    .n_rst (n_rst),
    .init  (accept),
    .en    (bit_en && (state_q == ST_DATA_BITS)),
    .din   (cur_bit),
    .crc   (crc16)
  );

  assign tx_bit    = cur_bit;
  assign tx_se0    = (state_q == ST_EOP_SE0);
  assign tx_active = (state_q != ST_IDLE);
  assign ready     = (state_q == ST_IDLE);
  assign data_rd   = (state_q == ST_DATA_BITS) && load_q;
  assign done      = done_q;

endmodule
